// File: rtl/exec_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the 16-bit execute stage.
package exec_pkg;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpAddu = 4'h1;
    localparam logic [3:0] OpAddc = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpCmp  = 4'h4;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpOr   = 4'h6;
    localparam logic [3:0] OpXor  = 4'h7;
    localparam logic [3:0] OpMov  = 4'h8;
    localparam logic [3:0] OpLsh  = 4'h9;
    localparam logic [3:0] OpMul  = 4'hA;
    localparam logic [3:0] OpNop  = 4'hF;

    localparam int unsigned FlagC = 0;
    localparam int unsigned FlagL = 1;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagN = 4;

    localparam int unsigned MulCyclesDefault = 16;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    // Logical ops and MUL treat the immediate as unsigned; everything else sign-extends it.
    function automatic logic imm_zero_ext(logic [3:0] op);
        return (op == OpAnd) || (op == OpOr) || (op == OpXor) || (op == OpMul);
    endfunction

endpackage

// File: rtl/exec_if.sv
// Decode-to-execute issue channel plus the writeback and status returned by the stage.
interface exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  dst_idx;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        wb_enable;
    logic [4:0]  wb_index;
    logic [15:0] wb_data;
    logic [4:0]  flags;
    logic        busy;

    modport master (
        output in_valid, op, dst_idx, a_data, b_data, imm, imm_sel,
        input  in_ready, wb_enable, wb_index, wb_data, flags, busy
    );

    modport slave (
        input  in_valid, op, dst_idx, a_data, b_data, imm, imm_sel,
        output in_ready, wb_enable, wb_index, wb_data, flags, busy
    );
endinterface

// File: rtl/mul_iter.sv
// Sequential shift-add multiplier producing the low 16 bits of an unsigned product.
// One step per cycle after start; result is the combinational value of the final step.
module mul_iter
    import exec_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MulCyclesDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] result
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);

    logic [15:0]     mcand_q;
    logic [15:0]     mplier_q;
    logic [15:0]     acc_q;
    logic [15:0]     acc_d;
    logic [CntW-1:0] cnt_q;
    logic            active_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
    end

    assign done   = active_q && (cnt_q == CntW'(MUL_CYCLES - 1));
    assign result = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            mcand_q  <= {mcand_q[14:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[15:1]};
            acc_q    <= acc_d;
            if (done) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with registered writeback and status flags.
// Define EXEC_MUL_EN to add the iterative multiplier and its back-pressure FSM.
module exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MulCyclesDefault
) (
    input logic   clk,
    input logic   rst_n,
    exec_if.slave bus
);

    logic        accept;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic        carry_in;
    logic [16:0] sum;
    logic        alu_wr;
    logic [15:0] alu_res;
    logic [4:0]  flags_d;

    logic        wb_enable_q;
    logic [4:0]  wb_index_q;
    logic [15:0] wb_data_q;
    logic [4:0]  flags_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign a_val  = bus.a_data;

    always_comb begin
        b_val = bus.b_data;
        if (bus.imm_sel) begin
            b_val = imm_zero_ext(bus.op) ? {8'h00, bus.imm} : {{8{bus.imm[7]}}, bus.imm};
        end
    end

    // ADDC consumes the C already committed, so a preceding ADD's carry is visible.
    assign carry_in = (bus.op == OpAddc) && flags_q[FlagC];

    always_comb begin
        alu_wr  = 1'b0;
        alu_res = '0;
        flags_d = flags_q;
        sum     = '0;
        case (bus.op)
            OpAdd, OpAddu, OpAddc: begin
                sum              = {1'b0, a_val} + {1'b0, b_val} + {16'd0, carry_in};
                alu_res          = sum[15:0];
                alu_wr           = 1'b1;
                flags_d[FlagC]   = sum[16];
                flags_d[FlagZ]   = (sum[15:0] == 16'h0000);
                if (bus.op != OpAddu) begin
                    flags_d[FlagF] = (a_val[15] == b_val[15]) && (sum[15] != a_val[15]);
                end
            end
            OpSub: begin
                sum            = {1'b0, a_val} - {1'b0, b_val};
                alu_res        = sum[15:0];
                alu_wr         = 1'b1;
                flags_d[FlagC] = sum[16];
                flags_d[FlagF] = (a_val[15] != b_val[15]) && (sum[15] != a_val[15]);
                flags_d[FlagZ] = (sum[15:0] == 16'h0000);
            end
            OpCmp: begin
                flags_d[FlagZ] = (a_val == b_val);
                flags_d[FlagL] = (a_val < b_val);
                flags_d[FlagN] = ($signed(a_val) < $signed(b_val));
            end
            OpAnd, OpOr, OpXor, OpMov, OpLsh: begin
                alu_wr = 1'b1;
                unique case (bus.op)
                    OpAnd:   alu_res = a_val & b_val;
                    OpOr:    alu_res = a_val | b_val;
                    OpXor:   alu_res = a_val ^ b_val;
                    OpMov:   alu_res = b_val;
                    default: alu_res = b_val[4] ? (a_val >> b_val[3:0]) : (a_val << b_val[3:0]);
                endcase
                flags_d[FlagZ] = (alu_res == 16'h0000);
            end
            default: ;
        endcase
    end

`ifdef EXEC_MUL_EN
    state_e      state_q;
    logic [4:0]  mul_dst_q;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_result;

    assign mul_start = accept && (bus.op == OpMul);

    mul_iter #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a_val),
        .b     (b_val),
        .done  (mul_done),
        .result(mul_result)
    );

    assign bus.in_ready = (state_q == StIdle);
    assign bus.busy     = (state_q == StMul);
`else
    logic unused_mul_cycles;
    assign unused_mul_cycles = ^MUL_CYCLES;

    assign bus.in_ready = 1'b1;
    assign bus.busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_enable_q <= 1'b0;
            wb_index_q  <= '0;
            wb_data_q   <= '0;
            flags_q     <= '0;
`ifdef EXEC_MUL_EN
            state_q     <= StIdle;
            mul_dst_q   <= '0;
`endif
        end else begin
            wb_enable_q <= 1'b0;
            if (accept) begin
                flags_q <= flags_d;
                if (alu_wr) begin
                    wb_enable_q <= 1'b1;
                    wb_index_q  <= bus.dst_idx;
                    wb_data_q   <= alu_res;
                end
            end
`ifdef EXEC_MUL_EN
            // Accepts never coincide with StMul since in_ready is low there.
            unique case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        state_q   <= StMul;
                        mul_dst_q <= bus.dst_idx;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        wb_enable_q    <= 1'b1;
                        wb_index_q     <= mul_dst_q;
                        wb_data_q      <= mul_result;
                        flags_q[FlagZ] <= (mul_result == 16'h0000);
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
`endif
        end
    end

    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_index  = wb_index_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized bench for exec_stage with an arithmetic reference model and directed pins.
module tb_exec_stage;

`ifdef EXEC_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    localparam int CB = 0, LB = 1, FB = 2, ZB = 3, NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exec_if bus ();

    exec_stage dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state and expected outputs for the current cycle.
    logic [4:0]  m_flags = '0;
    int          m_mul_left = 0;
    logic [15:0] m_mul_res = '0;
    logic [4:0]  m_mul_dst = '0;
    logic        e_wb_en = 1'b0;
    logic [4:0]  e_wb_idx = '0;
    logic [15:0] e_wb_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags    = '0;
        m_mul_left = 0;
        e_wb_en    = 1'b0;
        e_wb_idx   = '0;
        e_wb_data  = '0;
    endtask

    task automatic model_step();
        logic [3:0]  o;
        logic [15:0] a, b, res;
        logic [31:0] p;
        int          sa, sb, ss;
        int unsigned s, cin;
        bit          wr;
        e_wb_en = 1'b0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                e_wb_en     = 1'b1;
                e_wb_idx    = m_mul_dst;
                e_wb_data   = m_mul_res;
                m_flags[ZB] = (m_mul_res == 16'h0000);
            end
        end else if (bus.in_valid) begin
            o = bus.op;
            a = bus.a_data;
            if (bus.imm_sel)
                b = (o == 4'h5 || o == 4'h6 || o == 4'h7 || o == 4'hA) ?
                    {8'h00, bus.imm} : {{8{bus.imm[7]}}, bus.imm};
            else
                b = bus.b_data;
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            wr  = 1'b1;
            res = '0;
            case (o)
                4'h0, 4'h1, 4'h2: begin
                    cin = (o == 4'h2) ? int'(m_flags[CB]) : 0;
                    s   = int'(a) + int'(b) + cin;
                    res = s[15:0];
                    m_flags[CB] = (s > 65535);
                    if (o != 4'h1) begin
                        ss = sa + sb + int'(cin);
                        m_flags[FB] = (ss > 32767) || (ss < -32768);
                    end
                end
                4'h3: begin
                    res = a - b;
                    ss  = sa - sb;
                    m_flags[CB] = (a < b);
                    m_flags[FB] = (ss > 32767) || (ss < -32768);
                end
                4'h4: begin
                    wr = 1'b0;
                    m_flags[ZB] = (a == b);
                    m_flags[LB] = (a < b);
                    m_flags[NB] = (sa < sb);
                end
                4'h5: res = a & b;
                4'h6: res = a | b;
                4'h7: res = a ^ b;
                4'h8: res = b;
                4'h9: res = b[4] ? (a >> b[3:0]) : (a << b[3:0]);
                4'hA: begin
                    wr = 1'b0;
                    if (MulEn) begin
                        p          = {16'h0000, a} * {16'h0000, b};
                        m_mul_res  = p[15:0];
                        m_mul_dst  = bus.dst_idx;
                        m_mul_left = 16;
                    end
                end
                default: wr = 1'b0;
            endcase
            if (wr) begin
                e_wb_en     = 1'b1;
                e_wb_idx    = bus.dst_idx;
                e_wb_data   = res;
                m_flags[ZB] = (res == 16'h0000);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle, mid-way between rising edges.
    initial begin
        forever begin
            @(negedge clk);
            check("wb_enable", 32'(bus.wb_enable), 32'(e_wb_en));
            if (e_wb_en) begin
                check("wb_index", 32'(bus.wb_index), 32'(e_wb_idx));
                check("wb_data", 32'(bus.wb_data), 32'(e_wb_data));
            end
            check("flags", 32'(bus.flags), 32'(m_flags));
            check("busy", 32'(bus.busy), 32'(m_mul_left > 0));
            check("in_ready", 32'(bus.in_ready), 32'(m_mul_left == 0));
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic issue(input logic [3:0] o, input logic [4:0] d, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] im, input logic is);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.dst_idx  = d;
        bus.a_data   = a;
        bus.b_data   = b;
        bus.imm      = im;
        bus.imm_sel  = is;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int lo_cnt;
        logic [3:0] o;
        bus.in_valid = 1'b0;
        bus.op       = 4'hF;
        bus.dst_idx  = '0;
        bus.a_data   = '0;
        bus.b_data   = '0;
        bus.imm      = '0;
        bus.imm_sel  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", 32'(bus.flags), 32'h00);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'h0, 5'd1, 16'h7FFF, 16'h0001, 8'h00, 1'b0);
        check("pin_add_ovf_data", 32'(bus.wb_data), 32'h8000);
        check("pin_add_ovf_flags", 32'(bus.flags), 32'h04);
        check("pin_add_ovf_model", 32'(m_flags), 32'h04);
        issue(4'h0, 5'd2, 16'hFFFF, 16'h0001, 8'h00, 1'b0);
        check("pin_add_carry_data", 32'(bus.wb_data), 32'h0000);
        check("pin_add_carry_flags", 32'(bus.flags), 32'h09);
        issue(4'h2, 5'd3, 16'h0000, 16'h0000, 8'h00, 1'b0);
        check("pin_addc_data", 32'(bus.wb_data), 32'h0001);
        check("pin_addc_model", 32'(e_wb_data), 32'h0001);
        issue(4'h4, 5'd4, 16'h0003, 16'hFFFF, 8'h00, 1'b0);
        check("pin_cmp_noweb", 32'(bus.wb_enable), 32'd0);
        check("pin_cmp_flags", 32'(bus.flags), 32'h02);
        issue(4'h3, 5'd0, 16'h0005, 16'h0005, 8'h00, 1'b0);
        check("pin_sub_data", 32'(bus.wb_data), 32'h0000);
        check("pin_sub_flags", 32'(bus.flags), 32'h0A);
        issue(4'h5, 5'd5, 16'hFFFF, 16'h1234, 8'h80, 1'b1);
        check("pin_and_imm", 32'(bus.wb_data), 32'h0080);
        issue(4'h0, 5'd6, 16'h0010, 16'h1234, 8'hFF, 1'b1);
        check("pin_add_imm", 32'(bus.wb_data), 32'h000F);
        check("pin_add_imm_model", 32'(e_wb_data), 32'h000F);
        issue(4'h9, 5'd7, 16'h0001, 16'h0004, 8'h00, 1'b0);
        check("pin_lsh_left", 32'(bus.wb_data), 32'h0010);
        issue(4'h9, 5'd8, 16'h0100, 16'h0014, 8'h00, 1'b0);
        check("pin_lsh_right", 32'(bus.wb_data), 32'h0010);

        issue(4'hA, 5'd9, 16'd300, 16'd200, 8'h00, 1'b0);
        if (MulEn) begin
            lo_cnt = 0;
            repeat (16) begin
                if (!bus.in_ready) lo_cnt++;
                @(negedge clk);
            end
            check("pin_mul_ready_low", 32'(lo_cnt), 32'd16);
            check("pin_mul_wb_en", 32'(bus.wb_enable), 32'd1);
            check("pin_mul_data", 32'(bus.wb_data), 32'hEA60);
            check("pin_mul_model", 32'(e_wb_data), 32'hEA60);
        end else begin
            check("pin_mul_nop_wb", 32'(bus.wb_enable), 32'd0);
            check("pin_mul_nop_ready", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);

        issue(4'hA, 5'd10, 16'd300, 16'd200, 8'h00, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("pin_abort_ready", 32'(bus.in_ready), 32'd1);
        check("pin_abort_flags", 32'(bus.flags), 32'h00);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
            end else begin
                o = 4'($urandom_range(0, 15));
                if (o == 4'hA && $urandom_range(0, 3) != 0) o = 4'h2;
                issue(o, 5'($urandom_range(0, 31)), rnd_word(), rnd_word(),
                      8'($urandom()), 1'($urandom_range(0, 1)));
            end
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
